sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master that sits directly upstream of the system-ID slave: drives its 1-bit address and read, consumes its 32-bit readdata.
- After a start pulse (e.g. from boot/reset sequencing logic), reads the ID word (address 0) and then the timestamp word (address 1).
- Compares both against build-time parameters and reports pass/fail to status LEDs or a CPU-visible status register.
- Keeps FPGA image and software build matched without CPU involvement.

Parameters:
- EXPECTED_ID, 32'd0, ID value expected at address 0.
- EXPECTED_TS, 32'd1522343701, timestamp expected at address 1.
- CHECK_TS, 1, 1 = timestamp must match for pass; 0 = timestamp captured but ignored.
- TIMEOUT_CYCLES, 255, maximum waitrequest-high cycles per access before abort (1..255).
- MAX_RETRY, 3, retry limit; used only with the optional feature (1..3).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to run a check.
- avm_address  output  1  to slave address (0 = ID, 1 = timestamp).
- avm_read  output  1  Avalon read strobe.
- avm_readdata  input  32  slave readdata.
- avm_waitrequest  input  1  slave stall; tie to 0 for zero-wait slaves.
- busy  output  1  high while a check is in progress.
- done  output  1  sticky; set when a check completes, cleared by the next accepted start.
- pass  output  1  valid while done=1.
- timeout  output  1  valid while done=1; an access exceeded TIMEOUT_CYCLES.
- id_value  output  32  last captured ID word.
- ts_value  output  32  last captured timestamp word.
- retry_count  output  2  retries used in the last check.

Behaviour:
- Reset state (asynchronous assert, synchronous-to-clock release): all outputs 0, FSM in IDLE, timer 0.
- FSM states: IDLE, RD_ID, RD_TS, DONE.
- IDLE/DONE + start=1:
  - Next cycle enter RD_ID.
  - Clear done, pass and timeout; keep id_value and ts_value until overwritten.
  - Set retry_count to 0.
- start while in RD_ID or RD_TS is ignored.
- RD_ID:
  - Drives avm_read=1 and avm_address=0.
  - When waitrequest=0, capture readdata into id_value and go to RD_TS. avm_address becomes 1 on the following cycle; read stays high (back-to-back reads).
- RD_TS:
  - Same handshake with avm_address=1.
  - On acceptance, capture ts_value and go to DONE.
- Timer:
  - Counts cycles with waitrequest=1 in the current access; reset to 0 on each state entry.
  - When it reaches TIMEOUT_CYCLES with waitrequest still 1: go to DONE with timeout=1, pass=0. The pending read is abandoned (read drops).
- DONE:
  - avm_read=0, busy=0, done=1.
  - pass = (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS) && !timeout.
  - pass is registered and valid the same cycle done rises.
- busy = 1 exactly in RD_ID and RD_TS.
- Latency with waitrequest tied 0:
  - start at cycle N, RD_ID at N+1, RD_TS at N+2, done=1 at N+3.
  - Each waitrequest cycle adds one cycle.
- start coincident with reset deassertion is ignored; reset mid-check returns to IDLE immediately, with avm_read low asynchronously.

Optional Feature:
- Macro SYSID_CHECKER_RETRY_EN.
- Defined:
  - Entering DONE with pass=0 and retry_count<MAX_RETRY re-enters RD_ID the next cycle instead of asserting done; retry_count increments.
  - busy stays 1 throughout; done rises only on pass or when retries are exhausted.
- Undefined: no retries; retry_count is constant 0.

Decomposition:
- Package sysid_checker_pkg holds:
  - state enum (IDLE, RD_ID, RD_TS, DONE);
  - constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - TIMER_W=8.
- One natural sub-module: sysid_checker_timer (clear, enable, terminal-count compare against TIMEOUT_CYCLES).
- FSM, capture registers and compare logic stay in the top.

Test Plan:
- Zero-wait slave returning 0 / 1522343701; start pulse at cycle 10 -> done=1, pass=1 at cycle 13; id_value=0, ts_value=1522343701, avm_read high in cycles 11-12 only.
- Slave returns timestamp 1522343700 -> done=1, pass=0, timeout=0; repeat with CHECK_TS=0 -> pass=1.
- waitrequest held 3 cycles on the ID read -> done delayed by 3 cycles, pass=1; held permanently -> done after 255 stall cycles, timeout=1, pass=0, avm_read=0.
- start re-pulsed during RD_TS -> ignored, single completion; start pulsed in DONE -> done clears the next cycle and a new check completes.
- reset_n asserted in RD_TS -> same-cycle avm_read=0, all outputs 0; after release, start -> normal pass.
- With SYSID_CHECKER_RETRY_EN, ID wrong on the first 2 attempts and then correct -> pass=1, retry_count=2; always wrong -> pass=0, retry_count=3.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared types and constants for the system-ID checker.
package sysid_checker_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMER_W = 8;
  localparam int unsigned RETRY_W = 2;

  // System-ID slave word addresses
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Words captured from the system-ID slave
  typedef struct packed {
    logic [DATA_W-1:0] id;
    logic [DATA_W-1:0] ts;
  } sysid_words_t;

  // True in the states that own an outstanding Avalon read
  function automatic logic is_access(input state_e s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

endpackage

// File: rtl/sysid_checker_timer.sv
// sysid_checker_timer: per-access waitrequest stall counter with terminal-count flag.
// expired_c fires on the stall cycle that completes TIMEOUT_CYCLES stalls.
module sysid_checker_timer
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam logic [TIMER_W-1:0] LAST_STALL = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_q;

  // Stall counter: clear wins over count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

  assign expired_c = enable && (count_q == LAST_STALL);

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system-ID slave (ID word, then
// timestamp word) after a start pulse and reports whether both match build-time
// values. Optional macro SYSID_CHECKER_RETRY_EN re-runs a failed check up to
// MAX_RETRY times before reporting.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'd1522343701,
  parameter int unsigned       CHECK_TS       = 1,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter int unsigned       MAX_RETRY      = 3
)(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic               avm_address,
  output logic               avm_read,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_waitrequest,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [DATA_W-1:0]  id_value,
  output logic [DATA_W-1:0]  ts_value,
  output logic [RETRY_W-1:0] retry_count
);

`ifdef SYSID_CHECKER_RETRY_EN
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
`else
  // Retries compiled out: a zero limit makes the first result final.
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY - MAX_RETRY);
`endif

  localparam logic TS_MUST_MATCH = (CHECK_TS != 0);

  state_e             state_q;
  state_e             state_d;
  logic               armed_q;

  sysid_words_t       words_q;
  sysid_words_t       words_d;
  logic               read_q;
  logic               read_d;
  logic               addr_q;
  logic               addr_d;
  logic               busy_q;
  logic               busy_d;
  logic               done_q;
  logic               done_d;
  logic               pass_q;
  logic               pass_d;
  logic               tmo_q;
  logic               tmo_d;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;

  logic               in_access_c;
  logic               accept_c;
  logic               stall_c;
  logic               start_ok_c;
  logic               expired_c;
  logic               finish_c;
  logic               match_c;
  logic               retry_c;
  logic               timer_clear_c;

  // Handshake qualifiers for the current cycle
  assign in_access_c   = is_access(state_q);
  assign accept_c      = in_access_c && !avm_waitrequest;
  assign stall_c       = in_access_c && avm_waitrequest;
  // armed_q blocks a start that arrives together with reset release
  assign start_ok_c    = start && armed_q && !in_access_c;
  assign finish_c      = ((state_q == RD_TS) && accept_c) || expired_c;
  assign match_c       = (state_q == RD_TS) && accept_c
                         && (words_q.id == EXPECTED_ID)
                         && (!TS_MUST_MATCH || (avm_readdata == EXPECTED_TS));
  assign retry_c       = finish_c && !match_c && (retry_q != RETRY_LIMIT);
  assign timer_clear_c = !in_access_c || accept_c || expired_c;

  sysid_checker_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (timer_clear_c),
    .enable    (stall_c),
    .expired_c (expired_c)
  );

  // State register and start-arming flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok_c) state_d = RD_ID;
      end
      RD_ID: begin
        if (finish_c)      state_d = retry_c ? RD_ID : DONE;
        else if (accept_c) state_d = RD_TS;
      end
      RD_TS: begin
        if (finish_c) state_d = retry_c ? RD_ID : DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values, derived from the next state so outputs line up with it
  always_comb begin
    read_d  = is_access(state_d);
    busy_d  = is_access(state_d);
    addr_d  = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    done_d  = (state_d == DONE);
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    words_d = words_q;

    if (start_ok_c) begin
      pass_d  = 1'b0;
      tmo_d   = 1'b0;
      retry_d = '0;
    end

    if (accept_c && (state_q == RD_ID)) words_d.id = avm_readdata;
    if (accept_c && (state_q == RD_TS)) words_d.ts = avm_readdata;

    if (retry_c) begin
      retry_d = retry_q + RETRY_W'(1);
    end else if (finish_c) begin
      pass_d = match_c;
      tmo_d  = expired_c;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q  <= 1'b0;
      addr_q  <= SYSID_ADDR_ID;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      retry_q <= '0;
      words_q <= '0;
    end else begin
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      words_q <= words_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = tmo_q;
  assign retry_count = retry_q;
  assign id_value    = words_q.id;
  assign ts_value    = words_q.ts;

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: schedule-driven bench for sysid_checker. A transaction-level
// model lays out the whole run as a per-cycle table of inputs and expected outputs.
module tb_sysid_checker;

  localparam int          T_OUT  = 255;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1522343701;
  localparam int          NCYC   = 30000;
`ifdef SYSID_CHECKER_RETRY_EN
  localparam int          RLIM   = 3;
`else
  localparam int          RLIM   = 0;
`endif

  typedef struct {
    bit          rst_n;
    bit          start;
    bit          wreq;
    logic [31:0] rdata;
    bit          read;
    bit          addr;
    bit          done;
    bit          pass;
    bit          pass2;
    bit          tmo;
    logic [31:0] id;
    logic [31:0] ts;
    logic [1:0]  retry;
  } cyc_t;

  logic        clock   = 1'b1;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  logic        avm_address, avm_read, busy, done, pass, timeout;
  logic [31:0] id_value, ts_value;
  logic [1:0]  retry_count;
  logic        u2_address, u2_read, u2_busy, u2_done, u2_pass, u2_timeout;
  logic [31:0] u2_id, u2_ts;
  logic [1:0]  u2_retry;

  cyc_t        sched [NCYC];
  int          wp;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  bit          m_done, m_pass, m_pass2, m_tmo;
  logic [31:0] m_id, m_ts;
  logic [1:0]  m_retry;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1),
    .TIMEOUT_CYCLES(T_OUT), .MAX_RETRY(3)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value), .retry_count(retry_count)
  );

  // Same stimulus, timestamp ignored
  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(0),
    .TIMEOUT_CYCLES(T_OUT), .MAX_RETRY(3)
  ) u2 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(u2_address), .avm_read(u2_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(u2_busy), .done(u2_done), .pass(u2_pass), .timeout(u2_timeout),
    .id_value(u2_id), .ts_value(u2_ts), .retry_count(u2_retry)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  // Append one cycle: drive values plus the model's current visible outputs
  function automatic void put(bit rst_n, bit st, bit wreq, logic [31:0] rdata, bit rd, bit addr);
    if (wp >= NCYC) return;
    sched[wp].rst_n = rst_n;
    sched[wp].start = st;
    sched[wp].wreq  = wreq;
    sched[wp].rdata = rdata;
    sched[wp].read  = rd;
    sched[wp].addr  = addr;
    sched[wp].done  = m_done;
    sched[wp].pass  = m_pass;
    sched[wp].pass2 = m_pass2;
    sched[wp].tmo   = m_tmo;
    sched[wp].id    = m_id;
    sched[wp].ts    = m_ts;
    sched[wp].retry = m_retry;
    wp++;
  endfunction

  function automatic void do_reset(int n);
    m_done = 0; m_pass = 0; m_pass2 = 0; m_tmo = 0;
    m_id = '0; m_ts = '0; m_retry = '0;
    repeat (n) put(0, 0, 0, 32'h0, 0, 0);
  endfunction

  function automatic void idle(int n);
    repeat (n) put(1, 0, 0, $urandom, 0, 0);
  endfunction

  // One check: k1/k2 stall cycles per read (>= T_OUT means never granted),
  // first bad_id attempts return a wrong ID, rst_at = TS-phase cycle to reset in.
  function automatic void run_check(int k1, int k2, int bad_id, bit ts_bad, bit stray, int rst_at);
    int          attempt;
    int          n;
    bit          tmo, ok, ok2;
    logic [31:0] idv, tsv;
    attempt = 0;
    put(1, 1, 0, $urandom, 0, 0);
    m_done = 0; m_pass = 0; m_pass2 = 0; m_tmo = 0; m_retry = '0;
    while (1) begin
      idv = (attempt < bad_id) ? (EXP_ID ^ (32'h1 << $urandom_range(0, 31))) : EXP_ID;
      tsv = ts_bad ? (EXP_TS - 32'd1) : EXP_TS;
      tmo = 0;
      n = (k1 >= T_OUT) ? T_OUT : k1 + 1;
      for (int i = 0; i < n; i++)
        put(1, stray && ($urandom_range(0, 1) == 1), i < k1, (i < k1) ? $urandom : idv, 1, 0);
      if (k1 >= T_OUT) begin
        tmo = 1;
      end else begin
        m_id = idv;
        n = (k2 >= T_OUT) ? T_OUT : k2 + 1;
        for (int i = 0; i < n; i++) begin
          if (i == rst_at) begin
            do_reset(2);
            put(1, 1, 0, 32'h0, 0, 0);
            return;
          end
          put(1, stray && ($urandom_range(0, 1) == 1), i < k2, (i < k2) ? $urandom : tsv, 1, 1);
        end
        if (k2 >= T_OUT) tmo = 1;
        else             m_ts = tsv;
      end
      ok  = !tmo && (m_id == EXP_ID) && (m_ts == EXP_TS);
      ok2 = !tmo && (m_id == EXP_ID);
      if (ok || attempt == RLIM) begin
        m_done = 1; m_pass = ok; m_pass2 = ok2; m_tmo = tmo;
        break;
      end
      attempt++;
      m_retry = 2'(attempt);
    end
  endfunction

  task automatic drive(input int c);
    reset_n         = sched[c].rst_n;
    start           = sched[c].start;
    avm_waitrequest = sched[c].wreq;
    avm_readdata    = sched[c].rdata;
  endtask

  task automatic compare(input int c);
    check("avm_read",    avm_read,    sched[c].read);
    check("avm_address", avm_address, sched[c].addr);
    check("busy",        busy,        sched[c].read);
    check("done",        done,        sched[c].done);
    check("pass",        pass,        sched[c].pass);
    check("timeout",     timeout,     sched[c].tmo);
    check("id_value",    id_value,    sched[c].id);
    check("ts_value",    ts_value,    sched[c].ts);
    check("retry_count", retry_count, sched[c].retry);
`ifndef SYSID_CHECKER_RETRY_EN
    check("nots_read",    u2_read,    sched[c].read);
    check("nots_address", u2_address, sched[c].addr);
    check("nots_busy",    u2_busy,    sched[c].read);
    check("nots_done",    u2_done,    sched[c].done);
    check("nots_pass",    u2_pass,    sched[c].pass2);
    check("nots_timeout", u2_timeout, sched[c].tmo);
    check("nots_id",      u2_id,      sched[c].id);
    check("nots_ts",      u2_ts,      sched[c].ts);
    check("nots_retry",   u2_retry,   sched[c].retry);
`endif
  endtask

  // Per-cycle compare, away from the active edge
  initial begin
    forever begin
      @(negedge clock);
      if (cyc < wp) compare(cyc);
    end
  end

  // Build schedule, pin the model, then play it
  initial begin
    int s10, sb, s3, sto, sdn;
    int k1, k2, bad;
`ifdef SYSID_CHECKER_RETRY_EN
    int sr1, sr2;
`endif
    n_cmp = 0; n_bad = 0; wp = 0; cyc = 0;

    do_reset(4);
    put(1, 1, 0, 32'h0, 0, 0);           // start together with reset release
    idle(5);
    s10 = wp;
    run_check(0, 0, 0, 0, 0, -1);  idle(2);
    sb = wp;
    run_check(0, 0, 0, 1, 0, -1);  idle(1);
    s3 = wp;
    run_check(3, 0, 0, 0, 0, -1);  idle(2);
    sto = wp;
    run_check(T_OUT, 0, 0, 0, 0, -1); idle(1);
    run_check(0, 3, 0, 0, 1, -1);
    sdn = wp;                              // start in the first DONE cycle
    run_check(0, 0, 0, 0, 0, -1);  idle(2);
    run_check(0, 5, 0, 0, 0, 2);   idle(3);
    run_check(0, 0, 0, 0, 0, -1);  idle(2);
`ifdef SYSID_CHECKER_RETRY_EN
    sr1 = wp;
    run_check(0, 0, 2, 0, 0, -1);  idle(2);
    sr2 = wp;
    run_check(0, 0, 9, 0, 0, -1);  idle(2);
`endif
    for (int i = 0; i < 40; i++) begin
      k1  = ($urandom_range(0, 19) == 0) ? T_OUT : int'($urandom_range(0, 3));
      k2  = ($urandom_range(0, 19) == 0) ? T_OUT : int'($urandom_range(0, 3));
      bad = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 9) : 0;
      run_check(k1, k2, bad, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, -1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    // Hand-computed pins on the model
    check("pin_start_cycle", s10, 10);
    check("pin_rd_c10", sched[10].read, 0);
    check("pin_rd_c11", sched[11].read, 1);
    check("pin_addr_c11", sched[11].addr, 0);
    check("pin_addr_c12", sched[12].addr, 1);
    check("pin_rd_c13", sched[13].read, 0);
    check("pin_done_c12", sched[12].done, 0);
    check("pin_done_c13", sched[13].done, 1);
    check("pin_pass_c13", sched[13].pass, 1);
    check("pin_ts_c13", sched[13].ts, 32'd1522343701);
    check("pin_tsbad_pass", sched[sb+3].pass, 0);
    check("pin_tsbad_tmo", sched[sb+3].tmo, 0);
    check("pin_tsbad_pass2", sched[sb+3].pass2, 1);
    check("pin_stall3_done_m1", sched[s3+5].done, 0);
    check("pin_stall3_done", sched[s3+6].done, 1);
    check("pin_stall3_pass", sched[s3+6].pass, 1);
    check("pin_to_read_last", sched[sto+255].read, 1);
    check("pin_to_read_end", sched[sto+256].read, 0);
    check("pin_to_done", sched[sto+256].done, 1);
    check("pin_to_tmo", sched[sto+256].tmo, 1);
    check("pin_to_pass", sched[sto+256].pass, 0);
    check("pin_restart_done", sched[sdn].done, 1);
    check("pin_restart_clear", sched[sdn+1].done, 0);
`ifdef SYSID_CHECKER_RETRY_EN
    check("pin_retry2_done", sched[sr1+7].done, 1);
    check("pin_retry2_pass", sched[sr1+7].pass, 1);
    check("pin_retry2_cnt", sched[sr1+7].retry, 2);
    check("pin_retry3_done", sched[sr2+9].done, 1);
    check("pin_retry3_pass", sched[sr2+9].pass, 0);
    check("pin_retry3_cnt", sched[sr2+9].retry, 3);
`endif

    drive(0);
    for (int c = 1; c < wp; c++) begin
      @(posedge clock);
      cyc = c;
      #1 drive(c);
    end
    @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
